// File: rtl/mac_out_drain.sv
// Snapshots four MAC accumulator lanes on capture and drains the selected lanes
// one word at a time over a valid/ready output, lowest lane index first.
module mac_out_drain #(
    parameter int unsigned MAC_ACC_WIDTH = 32,
    parameter int unsigned LANES         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     capture,
    input  logic [3:0]               lane_mask,
    input  logic [MAC_ACC_WIDTH-1:0] in0,
    input  logic [MAC_ACC_WIDTH-1:0] in1,
    input  logic [MAC_ACC_WIDTH-1:0] in2,
    input  logic [MAC_ACC_WIDTH-1:0] in3,
    output logic [MAC_ACC_WIDTH-1:0] out_data,
    output logic [1:0]               out_lane,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     clr_overrun
);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t                   state;
    logic [MAC_ACC_WIDTH-1:0] hold [LANES];
    logic [LANES-1:0]         pend;

    logic                     xfer;
    logic                     can_load;
    logic                     accept;
    logic                     lost;
    logic [LANES-1:0]         pend_after;
    logic [LANES-1:0]         src_mask;
    logic [MAC_ACC_WIDTH-1:0] src [LANES];
    logic                     nxt_valid;
    logic [1:0]               nxt_lane;
    logic [MAC_ACC_WIDTH-1:0] nxt_data;

    // A new capture is taken when idle, or when the last pending lane leaves
    // this very cycle; the next word is then selected straight from the inputs.
    always_comb begin
        xfer       = out_valid & out_ready;
        pend_after = pend;
        if (xfer) begin
            pend_after[out_lane] = 1'b0;
        end
        can_load = (state == IDLE) || (xfer && (pend_after == '0));
        accept   = en & capture & (lane_mask != '0) & can_load;
        lost     = en & capture & (lane_mask != '0) & (state == DRAIN) & ~can_load;

        src_mask = accept ? lane_mask : pend_after;
        src[0]   = accept ? in0 : hold[0];
        src[1]   = accept ? in1 : hold[1];
        src[2]   = accept ? in2 : hold[2];
        src[3]   = accept ? in3 : hold[3];

        nxt_valid = 1'b0;
        nxt_lane  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (src_mask[i] && !nxt_valid) begin
                nxt_valid = 1'b1;
                nxt_lane  = 2'(i);
            end
        end
        nxt_data = nxt_valid ? src[nxt_lane] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                hold[i] <= '0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                hold[0] <= in0;
                hold[1] <= in1;
                hold[2] <= in2;
                hold[3] <= in3;
                pend    <= lane_mask;
            end else begin
                pend    <= pend_after;
            end

            state     <= nxt_valid ? DRAIN : IDLE;
            busy      <= nxt_valid;
            out_valid <= nxt_valid;
            out_lane  <= nxt_lane;
            out_data  <= nxt_data;

            if (clr_overrun) begin
                overrun <= 1'b0;
            end else if (lost) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_out_drain.sv
// Directed bench for mac_out_drain: expected words are queued when a capture is
// driven and compared against every valid output cycle.
module tb_mac_out_drain;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [1:0]   lane;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         capture;
    logic [3:0]   lane_mask;
    logic [W-1:0] in0, in1, in2, in3;
    logic [W-1:0] out_data;
    logic [1:0]   out_lane;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         overrun;
    logic         clr_overrun;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    mac_out_drain #(.MAC_ACC_WIDTH(W), .LANES(4)) dut (
        .clk(clk), .rst(rst), .en(en), .capture(capture), .lane_mask(lane_mask),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the words a capture must produce, lowest lane first.
    task automatic push_cap(input logic [3:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) q.push_back('{lane: 2'(i), data: v[i]});
        end
    endtask

    // Check the outputs for the current cycle, then advance one clock.
    task automatic tick();
        exp_t e;
        chk("valid", 64'(out_valid), 64'(q.size() != 0));
        if (out_valid && q.size() != 0) begin
            e = q[0];
            chk("lane", 64'(out_lane), 64'(e.lane));
            chk("data", 64'(out_data), 64'(e.data));
            if (out_ready) void'(q.pop_front());
        end else if (!out_valid) begin
            chk("idle_data", 64'(out_data), 64'd0);
            chk("idle_lane", 64'(out_lane), 64'd0);
        end
        @(posedge clk);
        #1;
        capture     = 1'b0;
        clr_overrun = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; capture = 1'b0; lane_mask = '0; out_ready = 1'b1;
        clr_overrun = 1'b0; in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        tick();

        // Full mask, always ready: four consecutive words one cycle after capture
        in0 = 32'h11; in1 = 32'h22; in2 = 32'h33; in3 = 32'h44;
        lane_mask = 4'hF; capture = 1'b1;
        tick();
        push_cap(4'hF, 32'h11, 32'h22, 32'h33, 32'h44);
        in0 = 32'hDEAD; in1 = 32'hBEEF; in2 = 32'h0; in3 = 32'h1;
        chk("busy_drain", 64'(busy), 64'd1);
        repeat (4) tick();
        chk("busy_done", 64'(busy), 64'd0);
        tick();

        // Sparse mask with back-pressure toggling; wide values pass unmodified
        in0 = 32'h0BAD_0000; in1 = 32'hFFFF_FFF0; in2 = 32'h1234_5678; in3 = 32'h8000_0001;
        lane_mask = 4'b1010; capture = 1'b1;
        tick();
        push_cap(4'b1010, in0, in1, in2, in3);
        for (int i = 0; i < 6; i++) begin
            out_ready = (i % 2 == 1);
            tick();
        end
        out_ready = 1'b1;

        // Capture during drain is lost and flags overrun; clear takes it down
        in0 = 32'hA0; in1 = 32'hA1; in2 = 32'hA2; in3 = 32'hA3;
        lane_mask = 4'hF; capture = 1'b1;
        tick();
        push_cap(4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        repeat (2) tick();
        in0 = 32'hB0; in1 = 32'hB1; in2 = 32'hB2; in3 = 32'hB3;
        capture = 1'b1;
        tick();
        chk("overrun_set", 64'(overrun), 64'd1);
        repeat (3) tick();
        chk("overrun_sticky", 64'(overrun), 64'd1);
        clr_overrun = 1'b1;
        tick();
        chk("overrun_clr", 64'(overrun), 64'd0);

        // Clear wins over a simultaneous lost capture
        in0 = 32'hC0; in1 = 32'hC1; lane_mask = 4'b0011; capture = 1'b1;
        tick();
        push_cap(4'b0011, 32'hC0, 32'hC1, 32'h0, 32'h0);
        out_ready = 1'b0; capture = 1'b1; clr_overrun = 1'b1;
        tick();
        chk("clr_priority", 64'(overrun), 64'd0);
        out_ready = 1'b1;
        repeat (3) tick();

        // Capture coincident with last-lane transfer reloads with no gap
        in0 = 32'hD0; in1 = 32'hD1; in2 = 32'hD2; in3 = 32'hD3;
        lane_mask = 4'hF; capture = 1'b1;
        tick();
        push_cap(4'hF, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
        repeat (3) tick();
        in0 = 32'hE0; in1 = 32'hE1; in2 = 32'hE2; in3 = 32'hE3;
        capture = 1'b1;
        tick();
        push_cap(4'hF, 32'hE0, 32'hE1, 32'hE2, 32'hE3);
        chk("b2b_overrun", 64'(overrun), 64'd0);
        repeat (5) tick();
        chk("b2b_overrun_end", 64'(overrun), 64'd0);

        // Reset mid-drain discards the remaining lanes
        in0 = 32'hF0; in1 = 32'hF1; in2 = 32'hF2; in3 = 32'hF3;
        lane_mask = 4'hF; capture = 1'b1;
        tick();
        push_cap(4'hF, 32'hF0, 32'hF1, 32'hF2, 32'hF3);
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_busy", 64'(busy), 64'd0);
        q.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (4) tick();

        // Empty mask and disabled capture produce nothing
        lane_mask = 4'h0; capture = 1'b1;
        tick();
        repeat (2) tick();
        chk("mask0_overrun", 64'(overrun), 64'd0);
        en = 1'b0; lane_mask = 4'hF; capture = 1'b1;
        tick();
        repeat (2) tick();
        chk("en0_busy", 64'(busy), 64'd0);

        // Draining proceeds with en low once started
        en = 1'b1; in0 = 32'h77; in2 = 32'h99; lane_mask = 4'b0101; capture = 1'b1;
        tick();
        push_cap(4'b0101, 32'h77, 32'h0, 32'h99, 32'h0);
        en = 1'b0;
        repeat (3) tick();
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac_out_drain.md
MAC_OUT_DRAIN -- requirements
Module: mac_out_drain

Interface
REQ-001 SHALL have parameter MAC_ACC_WIDTH, default 32: width of each captured accumulator lane and of out_data.
REQ-002 SHALL have parameter LANES, default 4: number of input lanes; only 4 is supported.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1: capture enable; when low, capture is ignored.
REQ-006 SHALL have port capture  input  1: single-cycle request to snapshot in0..in3 and lane_mask.
REQ-007 SHALL have port lane_mask  input  4: bit i set = lane i is emitted; sampled with capture.
REQ-008 SHALL have ports in0, in1, in2, in3  input  MAC_ACC_WIDTH each: accumulator outputs of the upstream MAC cluster.
REQ-009 SHALL have port out_data  output  MAC_ACC_WIDTH: emitted lane value.
REQ-010 SHALL have port out_lane  output  2: index of the lane on out_data.
REQ-011 SHALL have port out_valid  output  1: out_data/out_lane are valid.
REQ-012 SHALL have port out_ready  input  1: consumer accepts the word.
REQ-013 SHALL have port busy  output  1: high in state DRAIN.
REQ-014 SHALL have port overrun  output  1: sticky flag, a capture was lost.
REQ-015 SHALL have port clr_overrun  input  1: synchronous clear of overrun.

Function
REQ-016 SHALL implement a two-state FSM: IDLE, DRAIN.
REQ-017 SHALL, in IDLE with en=1 and capture=1 and lane_mask!=0, register in0..in3 and lane_mask into a holding buffer and enter DRAIN on the next edge.
REQ-018 SHALL, in IDLE with capture=1 and lane_mask==0, remain in IDLE, emit nothing and leave overrun unchanged.
REQ-019 SHALL, in DRAIN, present the lowest-index pending lane: out_valid=1, out_data=buffered value, out_lane=its index; the first word appears the cycle after capture (latency 1).
REQ-020 SHALL treat a transfer as out_valid & out_ready in the same cycle; on transfer, clear that lane's pending bit and present the next pending lane in the following cycle.
REQ-021 SHALL hold out_data and out_lane stable while out_valid=1 and out_ready=0.
REQ-022 SHALL return to IDLE after the last pending lane transfers; out_valid=0 the following cycle.
REQ-023 SHALL, when an accepted capture (en=1, lane_mask!=0) coincides with the last-lane transfer, reload the buffer and stay in DRAIN with no idle cycle (back-to-back).
REQ-024 SHALL, on capture with en=1 in DRAIN other than as in REQ-023, ignore the new data and set overrun=1.
REQ-025 SHALL give clr_overrun priority over a simultaneous overrun set (flag reads 0 next cycle).
REQ-026 SHALL continue draining when en=0; en gates only capture.
REQ-027 SHALL emit lanes unmodified (no truncation, sign extension or saturation).
REQ-028 SHALL drive out_data=0 and out_lane=0 whenever out_valid=0.

Reset
REQ-029 SHALL, while rst=1, force state IDLE, buffer and pending mask to 0, out_valid=0, out_data=0, out_lane=0, busy=0, overrun=0.
REQ-030 SHALL, on rst asserted mid-drain, discard pending lanes; no word is emitted after reset deasserts until a new capture.

Verification
REQ-031 SHALL be verified: capture with mask=4'hF, in0..3=32'h11,22,33,44, out_ready=1 -> lanes 0..3 with those values on 4 consecutive cycles starting 1 cycle after capture; then IDLE.
REQ-032 SHALL be verified: mask=4'b1010, out_ready toggled 1/0 each cycle -> only lanes 1 then 3 emitted; data stable on stalled cycles.
REQ-033 SHALL be verified: second capture 2 cycles into a 4-lane drain -> original 4 words emitted unchanged, overrun=1; clr_overrun -> overrun=0 next cycle.
REQ-034 SHALL be verified: capture coincident with last-lane transfer -> next cycle shows new lane 0 value, out_valid never drops, overrun stays 0.
REQ-035 SHALL be verified: rst pulsed after lane 1 transfer -> out_valid=0 immediately; no lanes 2/3 emitted; capture with mask=0 or en=0 -> no output.
